// File: rtl/sr04_pkg.sv
// sr04_pkg: shared types and default constants for the SR04 ranging scheduler.
//   sr04_state_e  - scheduler FSM state encoding (IDLE, FIRE, WAIT, GAP)
//   DIST_W/ERR_W  - distance and error-counter widths
//   DEF_*         - default parameter values for sr04_scheduler
//   clamp_cm()    - saturate a distance sample to a limit
package sr04_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } sr04_state_e;

  localparam int unsigned DIST_W = 10;
  localparam int unsigned ERR_W  = 8;

  localparam int unsigned DEF_TICK_DIV   = 100;
  localparam int unsigned DEF_PERIOD_US  = 60000;
  localparam int unsigned DEF_TIMEOUT_US = 30000;
  localparam int unsigned DEF_AVG_LOG2   = 2;
  localparam int unsigned DEF_MAX_CM     = 400;

  // Saturate a distance reading to lim.
  function automatic logic [DIST_W-1:0] clamp_cm(input logic [DIST_W-1:0] d,
                                                 input logic [DIST_W-1:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/sr04_avg.sv
// sr04_avg: moving-average window of 2**AVG_LOG2 distance samples.
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset; clears window, sum and avg
//   preload   - with sample_en, fill every window entry with sample
//   sample_en - accept sample this cycle
//   sample    - distance sample, cm
//   avg       - registered running sum >> AVG_LOG2 (truncated)
module sr04_avg
  import sr04_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              preload,
  input  logic              sample_en,
  input  logic [DIST_W-1:0] sample,
  output logic [DIST_W-1:0] avg
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = DIST_W + AVG_LOG2;

  logic [DIST_W-1:0] r_win [DEPTH];
  logic [SUM_W-1:0]  r_sum;
  logic [DIST_W-1:0] r_avg;
  logic [SUM_W-1:0]  w_sum_nxt;

  // Next running sum: preload replicates the sample; otherwise oldest out, newest in.
  always_comb begin
    w_sum_nxt = r_sum;
    if (preload) begin
      w_sum_nxt = SUM_W'(sample) << AVG_LOG2;
    end else begin
      w_sum_nxt = r_sum - SUM_W'(r_win[DEPTH-1]) + SUM_W'(sample);
    end
  end

  // Window shift register, sum and averaged output update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_win[i] <= '0;
      end
      r_sum <= '0;
      r_avg <= '0;
    end else if (sample_en) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (preload || i == 0) begin
          r_win[i] <= sample;
        end else begin
          r_win[i] <= r_win[i-1];
        end
      end
      r_sum <= w_sum_nxt;
      r_avg <= DIST_W'(w_sum_nxt >> AVG_LOG2);
    end
  end

  assign avg = r_avg;

endmodule

// File: rtl/sr04_scheduler.sv
// sr04_scheduler: periodic / single-shot trigger scheduler for an SR04 ranging
// controller, with timeout detection and moving-average filtering.
//   clk, rst          - clock (rising edge), asynchronous active-low reset
//   enable            - level, continuous periodic ranging while high
//   single_shot       - pulse, one measurement when idle
//   dist_in/dist_done - distance sample (cm) and its valid pulse
//   start             - one-cycle trigger to the ranging controller
//   dist_out/dist_valid - averaged distance and its update pulse
//   timeout_err/err_cnt - timeout pulse and saturating timeout count
//   busy              - high whenever the FSM is not IDLE
module sr04_scheduler
  import sr04_pkg::*;
#(
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned PERIOD_US  = DEF_PERIOD_US,
  parameter int unsigned TIMEOUT_US = DEF_TIMEOUT_US,
  parameter int unsigned AVG_LOG2   = DEF_AVG_LOG2,
  parameter int unsigned MAX_CM     = DEF_MAX_CM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              single_shot,
  input  logic [DIST_W-1:0] dist_in,
  input  logic              dist_done,
  output logic              start,
  output logic [DIST_W-1:0] dist_out,
  output logic              dist_valid,
  output logic              timeout_err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              busy
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PER_W = $clog2(PERIOD_US + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_US + 1);

  sr04_state_e       r_state;
  sr04_state_e       w_state_nxt;
  logic [PRE_W-1:0]  r_presc;
  logic [PER_W-1:0]  r_per;
  logic [TO_W-1:0]   r_to;
  logic              r_start;
  logic              r_valid;
  logic              r_tmo;
  logic [ERR_W-1:0]  r_err;
  logic              r_busy;
  logic              r_pend;
  logic              w_tick;
  logic              w_per_done;
  logic              w_to_hit;
  logic              w_accept;
  logic              w_tmo;
  logic [DIST_W-1:0] w_sample;
  logic [DIST_W-1:0] w_avg;

  assign w_tick   = (r_presc == PRE_W'(TICK_DIV - 1));
  // Period ends on the tick that brings the count to PERIOD_US, so the next
  // FIRE lands exactly PERIOD_US after the previous one.
  assign w_per_done = (r_per == PER_W'(PERIOD_US)) ||
                      (w_tick && (r_per == PER_W'(PERIOD_US - 1)));
  assign w_to_hit = (r_to == TO_W'(TIMEOUT_US));
  assign w_accept = (r_state == WAIT) && dist_done;
  // A sample arriving on the timeout cycle wins over the timeout.
  assign w_tmo    = (r_state == WAIT) && !dist_done && w_to_hit;
  assign w_sample = clamp_cm(dist_in, DIST_W'(MAX_CM));

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (enable || single_shot) w_state_nxt = FIRE;
      FIRE: w_state_nxt = WAIT;
      WAIT: if (dist_done || w_to_hit) w_state_nxt = GAP;
      GAP:  if (w_per_done) w_state_nxt = enable ? FIRE : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_start <= 1'b0;
      r_valid <= 1'b0;
      r_tmo   <= 1'b0;
      r_err   <= '0;
      r_busy  <= 1'b0;
      r_pend  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_start <= (r_state == FIRE);
      r_valid <= w_accept;
      r_tmo   <= w_tmo;
      if (w_tmo && (r_err != '1)) begin
        r_err <= r_err + ERR_W'(1);
      end
      // Preload the window with the first sample after reset or after IDLE.
      if (r_state == IDLE) begin
        r_pend <= 1'b1;
      end else if (w_accept) begin
        r_pend <= 1'b0;
      end
    end
  end

  // us timebase, period and timeout counters; zeroed on entry to FIRE so the
  // FIRE cycle is cycle 0 of the new interval.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_per   <= '0;
      r_to    <= '0;
    end else if (w_state_nxt == FIRE) begin
      r_presc <= '0;
      r_per   <= '0;
      r_to    <= '0;
    end else if (r_state != IDLE) begin
      r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
      if (w_tick && (r_per != PER_W'(PERIOD_US))) begin
        r_per <= r_per + PER_W'(1);
      end
      if (w_tick && (r_state != GAP) && !w_to_hit) begin
        r_to <= r_to + TO_W'(1);
      end
    end
  end

  sr04_avg #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk       (clk),
    .rst       (rst),
    .preload   (r_pend),
    .sample_en (w_accept),
    .sample    (w_sample),
    .avg       (w_avg)
  );

  assign start       = r_start;
  assign dist_out    = w_avg;
  assign dist_valid  = r_valid;
  assign timeout_err = r_tmo;
  assign err_cnt     = r_err;
  assign busy        = r_busy;

endmodule
